key_dispatch_arbiter: RTL and testbench

KEY_DISPATCH_ARBITER -- requirements
Module: key_dispatch_arbiter

---
 rtl/key_dispatch_pkg.sv | 17 +
 rtl/key_dispatch_arbiter_rr_pick.sv | 33 +++
 rtl/key_dispatch_arbiter.sv | 168 ++++++++++++++++
 tb/tb_key_dispatch_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/key_dispatch_pkg.sv
// Shared definitions for the key dispatch arbiter: FSM encoding and
// default values for the key-space parameters.
package key_dispatch_pkg;

   localparam int          KEY_W_DEF     = 24;
   localparam int unsigned KEY_START_DEF = 32'd0;
   localparam int unsigned KEY_MAX_DEF   = 32'h003F_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FOUND = 3'd3,
      ST_NONE  = 3'd4
   } state_e;

endpackage

// File: rtl/key_dispatch_arbiter_rr_pick.sv
// Rotating-priority picker: one-hot grant for the first set request bit at
// or after the base pointer, wrapping around the vector.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] base_i,
   output logic [N-1:0]  gnt_o,
   output logic          any_o
);

   always_comb begin
      logic [PW:0] pos;
      logic        hit;
      gnt_o = '0;
      hit   = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         // One extra bit holds base+k, which never reaches 2*N-1.
         pos = {1'b0, base_i} + (PW+1)'(k);
         if (pos >= (PW+1)'(N)) begin
            pos = pos - (PW+1)'(N);
         end
         if (!hit && req_i[pos[PW-1:0]]) begin
            gnt_o[pos[PW-1:0]] = 1'b1;
            hit                = 1'b1;
         end
      end
      any_o = hit;
   end

endmodule

// File: rtl/key_dispatch_arbiter.sv
// Hands out consecutive keys to a pool of decryption cores and records the
// first match. Optional KEY_PROGRESS_EN adds a saturating grant counter.
module key_dispatch_arbiter
   import key_dispatch_pkg::*;
#(
   parameter int          NUM_CORES = 4,
   parameter int          KEY_W     = KEY_W_DEF,
   parameter int unsigned KEY_START = KEY_START_DEF,
   parameter int unsigned KEY_MAX   = KEY_MAX_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             run,
   input  logic [NUM_CORES-1:0]             req,
   input  logic [NUM_CORES-1:0]             found,
   output logic [NUM_CORES-1:0]             start,
   output logic [NUM_CORES-1:0][KEY_W-1:0]  core_key,
   output logic [KEY_W-1:0]                 key_out,
   output logic                             busy,
   output logic                             done_found,
   output logic                             done_none,
   output logic [KEY_W:0]                   keys_issued,
   output state_e                           dbg_state_o
);

   localparam int              PW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [KEY_W-1:0] KEY_FIRST = KEY_W'(KEY_START);
   localparam logic [KEY_W-1:0] KEY_LAST  = KEY_W'(KEY_MAX);

   if (KEY_START > KEY_MAX) begin : g_bad_range
      $error("key_dispatch_arbiter: KEY_START must not exceed KEY_MAX");
   end
   if (NUM_CORES < 2 || NUM_CORES > 16) begin : g_bad_cores
      $error("key_dispatch_arbiter: NUM_CORES must be in 2..16");
   end

   state_e                            state_q, state_d;
   logic [KEY_W-1:0]                  next_key_q, next_key_d;
   logic [PW-1:0]                     ptr_q, ptr_d;
   logic [NUM_CORES-1:0]              outstanding_q, outstanding_d;
   logic [NUM_CORES-1:0]              start_q, start_d;
   logic [NUM_CORES-1:0][KEY_W-1:0]   core_key_q, core_key_d;
   logic [KEY_W-1:0]                  key_out_q, key_out_d;
   logic                              exhausted_q, exhausted_d;

   logic [NUM_CORES-1:0] elig;
   logic [NUM_CORES-1:0] g_gnt, f_gnt;
   logic                 g_any, f_any;
   logic [KEY_W-1:0]     found_key;
   logic [PW-1:0]        g_ptr;
   logic                 grant;

   // A core still showing start this cycle has not yet dropped its old req.
   assign elig = req & ~start_q;

   rr_pick #(.N(NUM_CORES), .PW(PW)) u_pick_req (
      .req_i  (elig),
      .base_i (ptr_q),
      .gnt_o  (g_gnt),
      .any_o  (g_any)
   );

   rr_pick #(.N(NUM_CORES), .PW(PW)) u_pick_found (
      .req_i  (found),
      .base_i (ptr_q),
      .gnt_o  (f_gnt),
      .any_o  (f_any)
   );

   always_comb begin
      found_key = '0;
      g_ptr     = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (f_gnt[i]) found_key = found_key | core_key_q[i];
         if (g_gnt[i]) g_ptr = (i == NUM_CORES-1) ? '0 : PW'(i + 1);
      end
   end

   always_comb begin
      state_d       = state_q;
      next_key_d    = next_key_q;
      ptr_d         = ptr_q;
      outstanding_d = outstanding_q;
      start_d       = '0;
      core_key_d    = core_key_q;
      key_out_d     = key_out_q;
      exhausted_d   = exhausted_q;
      grant         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_SCAN;
         end
         ST_SCAN, ST_DRAIN: begin
            outstanding_d = outstanding_q & ~(req | found);
            // A match outranks both new requests and exhaustion.
            if (f_any) begin
               state_d   = ST_FOUND;
               key_out_d = found_key;
            end else if (state_q == ST_SCAN && !exhausted_q && g_any) begin
               grant         = 1'b1;
               start_d       = g_gnt;
               outstanding_d = outstanding_d | g_gnt;
               ptr_d         = g_ptr;
               for (int i = 0; i < NUM_CORES; i++) begin
                  if (g_gnt[i]) core_key_d[i] = next_key_q;
               end
               if (next_key_q == KEY_LAST) begin
                  exhausted_d = 1'b1;
                  state_d     = ST_DRAIN;
               end else begin
                  next_key_d = next_key_q + KEY_W'(1);
               end
            end else if (state_q == ST_DRAIN && outstanding_q == '0) begin
               state_d = ST_NONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         next_key_q    <= KEY_FIRST;
         ptr_q         <= '0;
         outstanding_q <= '0;
         start_q       <= '0;
         core_key_q    <= '0;
         key_out_q     <= '0;
         exhausted_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         next_key_q    <= next_key_d;
         ptr_q         <= ptr_d;
         outstanding_q <= outstanding_d;
         start_q       <= start_d;
         core_key_q    <= core_key_d;
         key_out_q     <= key_out_d;
         exhausted_q   <= exhausted_d;
      end
   end

`ifdef KEY_PROGRESS_EN
   localparam logic [KEY_W:0] KEY_SPAN =
      (KEY_W+1)'(KEY_MAX) - (KEY_W+1)'(KEY_START) + (KEY_W+1)'(1);
   logic [KEY_W:0] issued_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         issued_q <= '0;
      end else if (grant && issued_q != KEY_SPAN) begin
         issued_q <= issued_q + (KEY_W+1)'(1);
      end
   end
   assign keys_issued = issued_q;
`else
   assign keys_issued = '0;
`endif

   assign start       = start_q;
   assign core_key    = core_key_q;
   assign key_out     = key_out_q;
   assign busy        = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done_found  = (state_q == ST_FOUND);
   assign done_none   = (state_q == ST_NONE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_dispatch_arbiter.sv
// Directed bench for key_dispatch_arbiter: a wide-key-space instance and a
// two-key instance for exhaustion, with grants tracked through a queue.
module tb_key_dispatch_arbiter;
   import key_dispatch_pkg::*;

`ifdef KEY_PROGRESS_EN
   localparam int PROG = 1;
`else
   localparam int PROG = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [11:0] exp_a_q[$];
   logic [11:0] exp_b_q[$];

   logic             rst_a, run_a, rst_b, run_b;
   logic [3:0]       req_a, found_a, req_b, found_b;
   logic [3:0]       start_a, start_b;
   logic [3:0][7:0]  core_key_a, core_key_b;
   logic [7:0]       key_out_a, key_out_b;
   logic             busy_a, busy_b, done_found_a, done_found_b, done_none_a, done_none_b;
   logic [8:0]       keys_issued_a, keys_issued_b;
   state_e           dbg_a, dbg_b;

   key_dispatch_arbiter #(.NUM_CORES(4), .KEY_W(8), .KEY_START(0), .KEY_MAX(255)) u_dut_a (
      .clk(clk), .reset(rst_a), .run(run_a), .req(req_a), .found(found_a),
      .start(start_a), .core_key(core_key_a), .key_out(key_out_a), .busy(busy_a),
      .done_found(done_found_a), .done_none(done_none_a), .keys_issued(keys_issued_a),
      .dbg_state_o(dbg_a)
   );

   key_dispatch_arbiter #(.NUM_CORES(4), .KEY_W(8), .KEY_START(254), .KEY_MAX(255)) u_dut_b (
      .clk(clk), .reset(rst_b), .run(run_b), .req(req_b), .found(found_b),
      .start(start_b), .core_key(core_key_b), .key_out(key_out_b), .busy(busy_b),
      .done_found(done_found_b), .done_none(done_none_b), .keys_issued(keys_issued_b),
      .dbg_state_o(dbg_b)
   );

   function automatic logic [11:0] grant_word(input logic [3:0] st, input logic [3:0][7:0] ck);
      logic [7:0] k;
      k = '0;
      for (int i = 0; i < 4; i++) if (st[i]) k = k | ck[i];
      return {st, k};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Any start pulse must match the oldest expected grant; none expected -> 0.
   always @(negedge clk) begin
      logic [11:0] obs_w, exp_w;
      if (start_a !== 4'b0000) begin
         obs_w = grant_word(start_a, core_key_a);
         exp_w = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 12'h000;
         checks++;
         assert (obs_w === exp_w) else begin
            failures++;
            $error("FAIL grant_a: observed=%0h expected=%0h", obs_w, exp_w);
         end
      end
      if (start_b !== 4'b0000) begin
         obs_w = grant_word(start_b, core_key_b);
         exp_w = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 12'h000;
         checks++;
         assert (obs_w === exp_w) else begin
            failures++;
            $error("FAIL grant_b: observed=%0h expected=%0h", obs_w, exp_w);
         end
      end
   end

   initial begin
      rst_a = 1'b1; run_a = 1'b0; req_a = '0; found_a = '0;
      rst_b = 1'b1; run_b = 1'b0; req_b = '0; found_b = '0;
      tick(); tick();

      check("rst_start",    start_a, 0);
      check("rst_core_key", core_key_a, 0);
      check("rst_key_out",  key_out_a, 0);
      check("rst_busy",     busy_a, 0);
      check("rst_found",    done_found_a, 0);
      check("rst_none",     done_none_a, 0);
      check("rst_issued",   keys_issued_a, 0);
      check("rst_state",    dbg_a, ST_IDLE);

      rst_a = 1'b0; rst_b = 1'b0; run_a = 1'b1;
      tick();
      check("scan_busy", busy_a, 1);

      // All four cores request; each drops req as soon as it sees its start.
      req_a = 4'b1111; exp_a_q.push_back({4'b0001, 8'd0}); tick();
      req_a = 4'b1110; exp_a_q.push_back({4'b0010, 8'd1}); tick();
      req_a = 4'b1100; exp_a_q.push_back({4'b0100, 8'd2}); tick();
      req_a = 4'b1000; exp_a_q.push_back({4'b1000, 8'd3}); tick();
      req_a = 4'b0000; tick();
      check("keys_0123",  core_key_a, 32'h0302_0100);
      check("issued_4",   keys_issued_a, PROG ? 4 : 0);

      req_a = 4'b0001; exp_a_q.push_back({4'b0001, 8'd4}); tick();
      req_a = 4'b0000; tick();
      check("issued_5",   keys_issued_a, PROG ? 5 : 0);
      check("key_core0",  core_key_a[0], 4);

      // Reset mid-search with a live request: nothing may be granted.
      rst_a = 1'b1; req_a = 4'b0010; tick();
      check("abort_start",    start_a, 0);
      check("abort_core_key", core_key_a, 0);
      check("abort_busy",     busy_a, 0);
      check("abort_issued",   keys_issued_a, 0);
      check("abort_state",    dbg_a, ST_IDLE);
      rst_a = 1'b0; req_a = 4'b0000; tick();

      req_a = 4'b0100; exp_a_q.push_back({4'b0100, 8'd0}); tick();
      req_a = 4'b0000; tick();
      req_a = 4'b1000; exp_a_q.push_back({4'b1000, 8'd1}); tick();
      req_a = 4'b0000; tick();
      req_a = 4'b0010; exp_a_q.push_back({4'b0010, 8'd2}); tick();
      req_a = 4'b0000; tick();
      check("rerun_issued", keys_issued_a, PROG ? 3 : 0);

      // ptr=2: found on cores 1 and 3 plus a request from core 0.
      found_a = 4'b1010; req_a = 4'b0001; tick();
      found_a = 4'b0000; req_a = 4'b0000;
      check("found_start", start_a, 0);
      check("found_flag",  done_found_a, 1);
      check("found_key",   key_out_a, 1);
      check("found_busy",  busy_a, 0);
      check("found_state", dbg_a, ST_FOUND);

      req_a = 4'b1111; found_a = 4'b0001; tick(); tick();
      req_a = 4'b0000; found_a = 4'b0000;
      check("found_hold_key",  key_out_a, 1);
      check("found_hold_none", done_none_a, 0);
      check("found_hold_flag", done_found_a, 1);

      // Two-key space: keys 254 and 255, then a third request is ignored.
      run_b = 1'b1; tick();
      req_b = 4'b0011; exp_b_q.push_back({4'b0001, 8'd254}); tick();
      req_b = 4'b0010; exp_b_q.push_back({4'b0010, 8'd255}); tick();
      req_b = 4'b0100; tick(); tick();
      req_b = 4'b0000;
      check("drain_busy",     busy_b, 1);
      check("drain_none",     done_none_b, 0);
      check("drain_issued",   keys_issued_b, PROG ? 2 : 0);
      check("drain_core_key", core_key_b, 32'h0000_FFFE);
      req_b = 4'b0011; tick();
      req_b = 4'b0000; tick();
      check("none_flag",  done_none_b, 1);
      check("none_busy",  busy_b, 0);
      check("none_found", done_found_b, 0);

      // Exhausted with core 2 still working; core 2 then matches.
      rst_b = 1'b1; tick();
      rst_b = 1'b0; tick();
      req_b = 4'b0001; exp_b_q.push_back({4'b0001, 8'd254}); tick();
      req_b = 4'b0000; tick();
      req_b = 4'b0100; exp_b_q.push_back({4'b0100, 8'd255}); tick();
      req_b = 4'b0000; tick();
      req_b = 4'b0001; tick();
      req_b = 4'b0000; tick();
      check("late_busy", busy_b, 1);
      check("late_none", done_none_b, 0);
      found_b = 4'b0100; tick();
      found_b = 4'b0000;
      check("late_found", done_found_b, 1);
      check("late_key",   key_out_b, 255);
      tick(); tick();
      check("late_none_stays", done_none_b, 0);

      check("queue_a_empty", exp_a_q.size(), 0);
      check("queue_b_empty", exp_b_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
